// File: rtl/sd_init_seq_pkg.sv
// rtl/sd_init_seq_pkg.sv - SD init command constants and sequencer state/step encodings
package sd_init_seq_pkg;

    localparam logic [5:0] CMD2_IDX   = 6'd2;
    localparam logic [5:0] CMD3_IDX   = 6'd3;
    localparam logic [5:0] CMD7_IDX   = 6'd7;
    localparam logic [5:0] CMD8_IDX   = 6'd8;
    localparam logic [5:0] CMD55_IDX  = 6'd55;
    localparam logic [5:0] ACMD41_IDX = 6'd41;

    localparam logic [31:0] CMD8_ARG       = 32'h0000_01AA;
    localparam logic [11:0] CMD8_CHECK     = 12'h1AA;
    localparam logic [31:0] ACMD41_ARG_HCS = 32'h40FF_8000;
    localparam logic [31:0] ACMD41_ARG_V1  = 32'h00FF_8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_RESP,
        ST_CHECK,
        ST_DELAY,
        ST_DONE,
        ST_FAIL
    } state_t;

    typedef enum logic [2:0] {
        STEP_CMD8,
        STEP_CMD55,
        STEP_ACMD41,
        STEP_CMD2,
        STEP_CMD3,
        STEP_CMD7
    } step_t;

    function automatic logic [5:0] step_index(input step_t s);
        logic [5:0] idx;
        case (s)
            STEP_CMD8:   idx = CMD8_IDX;
            STEP_CMD55:  idx = CMD55_IDX;
            STEP_ACMD41: idx = ACMD41_IDX;
            STEP_CMD2:   idx = CMD2_IDX;
            STEP_CMD3:   idx = CMD3_IDX;
            STEP_CMD7:   idx = CMD7_IDX;
            default:     idx = 6'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sd_init_seq.sv
// rtl/sd_init_seq.sv - SD card-identification sequencer (CMD8/ACMD41/CMD2/CMD3/CMD7)
// Optional CMD8 / HCS flow enabled by defining SD_INIT_CMD8_EN.
module sd_init_seq
    import sd_init_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_RETRY      = 1023,
    parameter int unsigned RETRY_GAP      = 255
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         istart,
    output logic         ostart,
    output logic [5:0]   ocmd_index,
    output logic [31:0]  ocmd_arg,
    input  logic [119:0] iresp,
    input  logic         idone,
    output logic         odone,
    output logic         ofail,
    output logic [15:0]  orca,
    output logic         occs
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned GAP_W = (RETRY_GAP < 2) ? 1 : $clog2(RETRY_GAP + 1);

`ifdef SD_INIT_CMD8_EN
    localparam step_t       FIRST_STEP = STEP_CMD8;
    localparam logic [31:0] ACMD41_ARG = ACMD41_ARG_HCS;
`else
    localparam step_t       FIRST_STEP = STEP_CMD55;
    localparam logic [31:0] ACMD41_ARG = ACMD41_ARG_V1;
`endif

    state_t             state_q, state_d;
    step_t              step_q, step_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               istart_q;
    logic               ostart_q, ostart_d;
    logic [5:0]         cmd_index_q, cmd_index_d;
    logic [31:0]        cmd_arg_q, cmd_arg_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [15:0]        rca_q, rca_d;
    logic               ccs_q, ccs_d;

    logic        start_edge;
    logic [31:0] tmo_inc, retry_inc, gap_inc;
    logic        tmo_hit, retry_hit, gap_hit;
    logic        cmd8_ok, acmd41_ready;
    logic        unused_resp;

    assign start_edge   = istart & ~istart_q;
    assign tmo_inc      = 32'(tmo_q) + 32'd1;
    assign retry_inc    = 32'(retry_q) + 32'd1;
    assign gap_inc      = 32'(gap_q) + 32'd1;
    assign tmo_hit      = (tmo_inc >= TIMEOUT_CYCLES);
    assign retry_hit    = (retry_inc >= MAX_RETRY);
    assign gap_hit      = (gap_inc >= RETRY_GAP);
    assign cmd8_ok      = (iresp[11:0] == CMD8_CHECK);
    assign acmd41_ready = iresp[31];
    assign unused_resp  = ^{iresp[119:32], iresp[15:12]};

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q     <= ST_IDLE;
            step_q      <= STEP_CMD8;
            tmo_q       <= '0;
            retry_q     <= '0;
            gap_q       <= '0;
            istart_q    <= 1'b0;
            ostart_q    <= 1'b0;
            cmd_index_q <= '0;
            cmd_arg_q   <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            rca_q       <= '0;
            ccs_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            gap_q       <= gap_d;
            istart_q    <= istart;
            ostart_q    <= ostart_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            rca_q       <= rca_d;
            ccs_q       <= ccs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: if (start_edge) state_d = ST_ISSUE;
            ST_ISSUE:                  state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!idone)       state_d = ST_WAIT_RESP;
                else if (tmo_hit) state_d = ST_FAIL;
            end
            ST_WAIT_RESP: begin
                if (idone)        state_d = ST_CHECK;
                else if (tmo_hit) state_d = ST_FAIL;
            end
            ST_CHECK: begin
                case (step_q)
                    STEP_CMD8:   state_d = cmd8_ok ? ST_ISSUE : ST_FAIL;
                    STEP_ACMD41: begin
                        if (acmd41_ready)   state_d = ST_ISSUE;
                        else if (retry_hit) state_d = ST_FAIL;
                        else                state_d = ST_DELAY;
                    end
                    STEP_CMD7:   state_d = ST_DONE;
                    default:     state_d = ST_ISSUE;
                endcase
            end
            ST_DELAY: if (gap_hit) state_d = ST_ISSUE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ostart is high exactly while waiting for the driver to go busy
    always_comb begin
        ostart_d    = (state_d == ST_WAIT_ACK);
        done_d      = (state_d == ST_DONE);
        fail_d      = (state_d == ST_FAIL);
        step_d      = step_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        gap_d       = gap_q;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        rca_d       = rca_q;
        ccs_d       = ccs_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start_edge) begin
                    step_d  = FIRST_STEP;
                    retry_d = '0;
                end
            end
            ST_ISSUE: begin
                cmd_index_d = step_index(step_q);
                tmo_d       = '0;
                case (step_q)
                    STEP_CMD8:   cmd_arg_d = CMD8_ARG;
                    STEP_ACMD41: cmd_arg_d = ACMD41_ARG;
                    STEP_CMD7:   cmd_arg_d = {rca_q, 16'h0000};
                    default:     cmd_arg_d = 32'h0000_0000;
                endcase
            end
            ST_WAIT_ACK, ST_WAIT_RESP: tmo_d = TMO_W'(tmo_inc);
            ST_CHECK: begin
                case (step_q)
                    STEP_CMD8:   step_d = STEP_CMD55;
                    STEP_CMD55:  step_d = STEP_ACMD41;
                    STEP_ACMD41: begin
                        if (acmd41_ready) begin
                            ccs_d  = iresp[30];
                            step_d = STEP_CMD2;
                        end else begin
                            retry_d = RTY_W'(retry_inc);
                            gap_d   = '0;
                        end
                    end
                    STEP_CMD2:   step_d = STEP_CMD3;
                    STEP_CMD3: begin
                        rca_d  = iresp[31:16];
                        step_d = STEP_CMD7;
                    end
                    default:     step_d = step_q;
                endcase
            end
            ST_DELAY: begin
                gap_d = GAP_W'(gap_inc);
                if (gap_hit) step_d = STEP_CMD55;
            end
            default: ;
        endcase
    end

    assign ostart     = ostart_q;
    assign ocmd_index = cmd_index_q;
    assign ocmd_arg   = cmd_arg_q;
    assign odone      = done_q;
    assign ofail      = fail_q;
    assign orca       = rca_q;
    assign occs       = ccs_q;

endmodule

// File: tb/tb_sd_init_seq.sv
// tb/tb_sd_init_seq.sv - directed bench for sd_init_seq with a scripted CMD driver model
module tb_sd_init_seq;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [31:0] resp;
        int          gap;
    } vec_t;

`ifdef SD_INIT_CMD8_EN
    localparam logic [31:0] A41 = 32'h40FF_8000;
    localparam int          G0  = 3;
`else
    localparam logic [31:0] A41 = 32'h00FF_8000;
    localparam int          G0  = 1;
`endif
    localparam logic [31:0] BUSY  = 32'h00FF_8000;
    localparam logic [31:0] READY = 32'hC0FF_8000;

    logic         iclk, irst, istart, ostart, idone, odone, ofail, occs;
    logic [5:0]   ocmd_index;
    logic [31:0]  ocmd_arg;
    logic [119:0] iresp;
    logic [15:0]  orca;

    int n_pass = 0;
    int n_total = 0;
    vec_t nom[$];
    vec_t busy[$];
    int cmd3_pos;

    sd_init_seq #(.TIMEOUT_CYCLES(20), .MAX_RETRY(3), .RETRY_GAP(4)) dut (
        .iclk(iclk), .irst(irst), .istart(istart), .ostart(ostart),
        .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg), .iresp(iresp), .idone(idone),
        .odone(odone), .ofail(ofail), .orca(orca), .occs(occs)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [5:0] i, input logic [31:0] a,
                                input logic [31:0] r, input int g);
        vec_t v;
        v.idx = i; v.arg = a; v.resp = r; v.gap = g;
        return v;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic do_start(input bit hold);
        @(negedge iclk); istart = 1'b1;
        @(negedge iclk); if (!hold) istart = 1'b0;
    endtask

    // Wait for a command, check it, then act as the driver: busy, then respond.
    task automatic serve(input vec_t v, input string tag);
        int n;
        n = 0;
        while (ostart !== 1'b1 && n < 50) begin @(negedge iclk); n++; end
        check_eq({tag, "_gap"}, 64'(n), 64'(v.gap));
        if (ostart !== 1'b1) return;
        check_eq({tag, "_idx"}, 64'(ocmd_index), 64'(v.idx));
        check_eq({tag, "_arg"}, 64'(ocmd_arg), 64'(v.arg));
        @(negedge iclk); idone = 1'b0;
        @(negedge iclk);
        check_eq({tag, "_ostart_low"}, 64'(ostart), 64'd0);
        repeat (2) @(negedge iclk);
        iresp = {82'd0, v.idx, v.resp};
        idone = 1'b1;
    endtask

    task automatic expect_end(input bit exp_done, input string tag);
        @(negedge iclk);
        check_eq({tag, "_check_odone"}, 64'(odone), 64'd0);
        check_eq({tag, "_check_ofail"}, 64'(ofail), 64'd0);
        @(negedge iclk);
        check_eq({tag, "_odone"}, 64'(odone), 64'(exp_done));
        check_eq({tag, "_ofail"}, 64'(ofail), 64'(!exp_done));
    endtask

    task automatic count_ostart(input int cycles, output int c);
        c = 0;
        repeat (cycles) begin @(negedge iclk); if (ostart) c++; end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ostart"}, 64'(ostart), 64'd0);
        check_eq({tag, "_index"}, 64'(ocmd_index), 64'd0);
        check_eq({tag, "_arg"}, 64'(ocmd_arg), 64'd0);
        check_eq({tag, "_odone"}, 64'(odone), 64'd0);
        check_eq({tag, "_ofail"}, 64'(ofail), 64'd0);
        check_eq({tag, "_orca"}, 64'(orca), 64'd0);
        check_eq({tag, "_occs"}, 64'(occs), 64'd0);
    endtask

    initial begin
        int c, n;
        irst = 1'b1; istart = 1'b0; idone = 1'b1; iresp = '0;

`ifdef SD_INIT_CMD8_EN
        nom.push_back(mk(6'd8, 32'h0000_01AA, 32'h0000_01AA, 1));
        busy.push_back(mk(6'd8, 32'h0000_01AA, 32'h0000_01AA, 1));
`endif
        nom.push_back(mk(6'd55, 32'h0, 32'h0000_0120, G0));
        nom.push_back(mk(6'd41, A41, BUSY, 3));
        nom.push_back(mk(6'd55, 32'h0, 32'h0000_0120, 7));
        nom.push_back(mk(6'd41, A41, BUSY, 3));
        nom.push_back(mk(6'd55, 32'h0, 32'h0000_0120, 7));
        nom.push_back(mk(6'd41, A41, READY, 3));
        nom.push_back(mk(6'd2, 32'h0, 32'h0, 3));
        cmd3_pos = nom.size();
        nom.push_back(mk(6'd3, 32'h0, 32'h1234_0000, 3));
        nom.push_back(mk(6'd7, 32'h1234_0000, 32'h0, 3));

        busy.push_back(mk(6'd55, 32'h0, 32'h0000_0120, G0));
        busy.push_back(mk(6'd41, A41, BUSY, 3));
        busy.push_back(mk(6'd55, 32'h0, 32'h0000_0120, 7));
        busy.push_back(mk(6'd41, A41, BUSY, 3));
        busy.push_back(mk(6'd55, 32'h0, 32'h0000_0120, 7));
        busy.push_back(mk(6'd41, A41, BUSY, 3));

        repeat (3) @(negedge iclk);
        check_reset_outputs("rst");
        irst = 1'b0;

        do_start(1'b0);
        for (int i = 0; i < nom.size(); i++) serve(nom[i], $sformatf("nom1_%0d", i));
        expect_end(1'b1, "nom1");
        check_eq("nom1_orca", 64'(orca), 64'h1234);
        check_eq("nom1_occs", 64'(occs), 64'd1);

        do_start(1'b1);
        for (int i = 0; i < nom.size(); i++) serve(nom[i], $sformatf("nom2_%0d", i));
        expect_end(1'b1, "nom2");
        count_ostart(10, c);
        check_eq("hold_no_restart", 64'(c), 64'd0);
        check_eq("hold_odone_kept", 64'(odone), 64'd1);

        @(negedge iclk); istart = 1'b0;
        do_start(1'b0);
        for (int i = 0; i < cmd3_pos; i++) serve(nom[i], $sformatf("run3_%0d", i));
        n = 0;
        while (ostart !== 1'b1 && n < 50) begin @(negedge iclk); n++; end
        check_eq("run3_cmd3_idx", 64'(ocmd_index), 64'd3);
        @(negedge iclk); idone = 1'b0;
        repeat (2) @(negedge iclk);
        irst = 1'b1;
        @(negedge iclk); irst = 1'b0; idone = 1'b1;
        check_reset_outputs("abort");
        do_start(1'b0);
        serve(nom[0], "restart_first");
        irst = 1'b1;
        @(negedge iclk); irst = 1'b0;

`ifdef SD_INIT_CMD8_EN
        do_start(1'b0);
        serve(mk(6'd8, 32'h0000_01AA, 32'h0000_00AA, 1), "cmd8_bad");
        expect_end(1'b0, "cmd8_bad");
        count_ostart(10, c);
        check_eq("cmd8_bad_no_cmd55", 64'(c), 64'd0);
`endif

        do_start(1'b0);
        for (int i = 0; i < busy.size(); i++) serve(busy[i], $sformatf("busy_%0d", i));
        expect_end(1'b0, "busy");
        count_ostart(10, c);
        check_eq("busy_no_more_cmds", 64'(c), 64'd0);

        do_start(1'b0);
        n = 0;
        while (ostart !== 1'b1 && n < 50) begin @(negedge iclk); n++; end
        check_eq("tmo_gap", 64'(n), 64'd1);
        n = 0;
        while (ofail !== 1'b1 && n < 100) begin @(negedge iclk); n++; end
        check_eq("tmo_latency", 64'(n), 64'd20);
        check_eq("tmo_ostart_low", 64'(ostart), 64'd0);
        check_eq("tmo_odone", 64'(odone), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
